// File: rtl/cache_controller.sv
// Direct-mapped, read-only cache controller in front of main_memory.
// Four-word lines; misses fetch the whole block after a fixed memory latency.
module cache_controller #(
    parameter int SETS        = 1024,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [14:0]      req_addr,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic             resp_hit,
    output logic [14:0]      mem_address,
    output logic             mem_hit,
    input  logic [31:0]      mem_data1,
    input  logic [31:0]      mem_data2,
    input  logic [31:0]      mem_data3,
    input  logic [31:0]      mem_data4,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] access_count
);

    // state   | meaning
    // IDLE    | ready for a request
    // LOOKUP  | tag compare on the latched address
    // FILL    | block fetch from main_memory, MEM_LATENCY cycles
    // RESPOND | resp_valid pulse

    localparam int IW = $clog2(SETS);
    localparam int TW = 13 - IW;
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;

    state_t state, state_nxt;

    logic [14:0]     addr_q;
    logic [CW-1:0]   fill_cnt;
    logic [SETS-1:0] valid;
    logic [TW-1:0]   tag_mem  [SETS];
    logic [127:0]    data_mem [SETS];

    logic [IW-1:0]   idx;
    logic [TW-1:0]   tag;
    logic [1:0]      off;
    logic            lookup_hit;
    logic            fill_done;
    logic [127:0]    line_rd;
    logic [31:0]     hit_word;
    logic [31:0]     fill_word;

    assign idx        = addr_q[IW+1:2];
    assign tag        = addr_q[14:IW+2];
    assign off        = addr_q[1:0];
    assign line_rd    = data_mem[idx];
    assign lookup_hit = valid[idx] && (tag_mem[idx] == tag);
    assign fill_done  = (state == FILL) && (fill_cnt == '0);
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESPOND);

    always_comb begin
        hit_word  = line_rd[31:0];
        fill_word = mem_data1;
        case (off)
            2'd1: begin hit_word = line_rd[63:32];   fill_word = mem_data2; end
            2'd2: begin hit_word = line_rd[95:64];   fill_word = mem_data3; end
            2'd3: begin hit_word = line_rd[127:96];  fill_word = mem_data4; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = lookup_hit ? RESPOND : FILL;
            FILL:    if (fill_cnt == '0) state_nxt = RESPOND;
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            fill_cnt     <= '0;
            valid        <= '0;
            resp_data    <= '0;
            resp_hit     <= 1'b0;
            mem_address  <= '0;
            mem_hit      <= 1'b1;
            hit_count    <= '0;
            access_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    addr_q <= req_addr;
                    if (access_count != {CNT_W{1'b1}})
                        access_count <= access_count + 1'b1;
                end
                LOOKUP: if (lookup_hit) begin
                    resp_data <= hit_word;
                    resp_hit  <= 1'b1;
                    if (hit_count != {CNT_W{1'b1}})
                        hit_count <= hit_count + 1'b1;
                end else begin
                    // counter counts down the remaining FILL edges after this one
                    fill_cnt    <= CW'(MEM_LATENCY - 1);
                    mem_address <= {addr_q[14:2], 2'b00};
                    mem_hit     <= 1'b0;
                end
                FILL: if (fill_cnt == '0) begin
                    valid[idx] <= 1'b1;
                    resp_data  <= fill_word;
                    resp_hit   <= 1'b0;
                    mem_hit    <= 1'b1;
                end else begin
                    fill_cnt <= fill_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // arrays are not reset; valid bits gate their use
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= {mem_data4, mem_data3, mem_data2, mem_data1};
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller; main memory modelled as RAM[a] = a.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [14:0] req_addr;
    logic        req_ready, resp_valid, resp_hit, mem_hit;
    logic [31:0] resp_data;
    logic [14:0] mem_address;
    logic [31:0] mem_data1, mem_data2, mem_data3, mem_data4;
    logic [15:0] hit_count, access_count;

    int n_vec = 0;
    int n_err = 0;

    cache_controller dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_hit(resp_hit), .mem_address(mem_address), .mem_hit(mem_hit),
        .mem_data1(mem_data1), .mem_data2(mem_data2), .mem_data3(mem_data3),
        .mem_data4(mem_data4), .hit_count(hit_count), .access_count(access_count)
    );

    always #5 clk = ~clk;

    assign mem_data1 = mem_hit ? 32'hdeadbeef : {17'd0, mem_address};
    assign mem_data2 = mem_hit ? 32'hdeadbeef : {17'd0, mem_address} + 32'd1;
    assign mem_data3 = mem_hit ? 32'hdeadbeef : {17'd0, mem_address} + 32'd2;
    assign mem_data4 = mem_hit ? 32'hdeadbeef : {17'd0, mem_address} + 32'd3;

    // Issues one read from a negedge and returns at the negedge where resp_valid is seen.
    task automatic issue_read(input logic [14:0] a, output int lat, output logic [31:0] d,
                              output logic h, output int lowc, output logic addr_bad);
        int w;
        lat = -1; d = '0; h = 1'bx; lowc = 0; addr_bad = 1'b0; w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = ~a;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!mem_hit) begin
                lowc++;
                if (mem_address !== {a[14:2], 2'b00}) addr_bad = 1'b1;
            end
            if (resp_valid) begin
                lat = i; d = resp_data; h = resp_hit;
                break;
            end
        end
    endtask

    task automatic check_read(input string name, input logic [14:0] a, input logic [31:0] ed,
                              input logic eh, input int elat, input int elow);
        int lat, lowc;
        logic [31:0] d;
        logic h, bad;
        issue_read(a, lat, d, h, lowc, bad);
        n_vec++;
        if (lat !== elat || d !== ed || h !== eh || lowc !== elow || bad !== 1'b0) begin
            n_err++;
            $display("FAIL %s: lat=%0d data=%0d hit=%0b memlow=%0d addrbad=%0b, want lat=%0d data=%0d hit=%0b memlow=%0d addrbad=0",
                     name, lat, d, h, lowc, bad, elat, ed, eh, elow);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({req_ready, resp_valid, resp_hit, mem_hit} !== 4'b1001 || resp_data !== 32'd0 ||
            mem_address !== 15'd0 || hit_count !== 16'd0 || access_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_values: rdy=%0b rv=%0b rh=%0b mh=%0b rd=%0d ma=%0d hc=%0d ac=%0d, want 1 0 0 1 0 0 0 0",
                     req_ready, resp_valid, resp_hit, mem_hit, resp_data, mem_address, hit_count, access_count);
        end
    endtask

    task automatic check_counts(input string name, input logic [15:0] eacc, input logic [15:0] ehit);
        n_vec++;
        if (access_count !== eacc || hit_count !== ehit) begin
            n_err++;
            $display("FAIL %s: access=%0h hit=%0h, want access=%0h hit=%0h", name, access_count, hit_count, eacc, ehit);
        end
    endtask

    task automatic test_miss_fill;
        check_read("cold_miss_1024", 15'd1024, 32'd1024, 1'b0, 6, 4);
        check_counts("counts_after_miss", 16'd1, 16'd0);
    endtask

    task automatic test_hits;
        check_read("hit_1025", 15'd1025, 32'd1025, 1'b1, 2, 0);
        check_read("hit_1026", 15'd1026, 32'd1026, 1'b1, 2, 0);
        check_read("hit_1027", 15'd1027, 32'd1027, 1'b1, 2, 0);
        check_counts("counts_after_hits", 16'd4, 16'd3);
    endtask

    task automatic test_conflict;
        check_read("conflict_5120", 15'd5120, 32'd5120, 1'b0, 6, 4);
        check_read("refill_1024", 15'd1024, 32'd1024, 1'b0, 6, 4);
        check_read("restored_1026", 15'd1026, 32'd1026, 1'b1, 2, 0);
        check_counts("counts_after_conflict", 16'd7, 16'd4);
    endtask

    task automatic test_back_to_back;
        int nresp, w;
        int at [8];
        logic bad;
        nresp = 0; w = 0; bad = 1'b0;
        @(negedge clk);
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        req_valid = 1'b1;
        req_addr  = 15'd1025;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (nresp < 8) at[nresp] = i;
                nresp++;
                if (resp_data !== 32'd1025 || resp_hit !== 1'b1) bad = 1'b1;
            end
            if (i == 12) req_valid = 1'b0;
        end
        n_vec++;
        if (nresp !== 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d responses, want 4", nresp);
        end
        n_vec++;
        if (nresp == 4 && (at[0] !== 2 || at[1] !== 5 || at[2] !== 8 || at[3] !== 11)) begin
            n_err++;
            $display("FAIL b2b_spacing: at %0d %0d %0d %0d, want 2 5 8 11", at[0], at[1], at[2], at[3]);
        end
        n_vec++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_data: a response was not a hit with data 1025");
        end
        check_counts("counts_after_b2b", 16'd11, 16'd8);
    endtask

    task automatic test_reset_mid_fill;
        int w, seen;
        w = 0; seen = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        req_valid = 1'b1;
        req_addr  = 15'd2048;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (mem_hit !== 1'b0 || mem_address !== 15'd2048) begin
            n_err++;
            $display("FAIL fill_in_progress: mem_hit=%0b mem_address=%0d, want 0 2048", mem_hit, mem_address);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({req_ready, resp_valid, resp_hit, mem_hit} !== 4'b1001 || resp_data !== 32'd0 ||
            mem_address !== 15'd0 || hit_count !== 16'd0 || access_count !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: rdy=%0b rv=%0b rh=%0b mh=%0b rd=%0d ma=%0d hc=%0d ac=%0d, want 1 0 0 1 0 0 0 0",
                     req_ready, resp_valid, resp_hit, mem_hit, resp_data, mem_address, hit_count, access_count);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL no_resp_after_reset: saw %0d responses, want 0", seen);
        end
        check_read("reread_2048", 15'd2048, 32'd2048, 1'b0, 6, 4);
        check_read("reset_cleared_1024", 15'd1024, 32'd1024, 1'b0, 6, 4);
        check_counts("counts_after_reset", 16'd2, 16'd0);
    endtask

    task automatic test_saturation;
        @(negedge clk);
        force dut.access_count = 16'hFFFE;
        #1 release dut.access_count;
        check_counts("forced_access", 16'hFFFE, 16'd0);
        check_read("sat_read_1", 15'd2049, 32'd2049, 1'b1, 2, 0);
        check_counts("sat_after_1", 16'hFFFF, 16'd1);
        check_read("sat_read_2", 15'd2050, 32'd2050, 1'b1, 2, 0);
        check_read("sat_read_3", 15'd2051, 32'd2051, 1'b1, 2, 0);
        check_counts("sat_after_3", 16'hFFFF, 16'd3);
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hits();
        test_conflict();
        test_back_to_back();
        test_reset_mid_fill();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
